// File: rtl/i2c_wr24_master.sv
// Single-shot I2C write master: START, 3 bytes MSB first with ACK checks, STOP, bus-free gap.
// Latency 116 quarter-periods start->done (14500 clk @ 50MHz/100kHz); start is ignored while busy or in the done cycle.
`timescale 1ns/1ps
module i2c_wr24_master #(
  parameter int CLK_FREQ = 50000000,
  parameter int SCL_FREQ = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] data_in,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        scl,
  output logic        sda_oe,
  input  logic        sda_in
);

  localparam int QDIV = CLK_FREQ / (4 * SCL_FREQ);
  localparam int QW   = $clog2(QDIV);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_FREE} state_t;

  state_t        state, state_n;
  logic [QW-1:0] qcnt;
  logic [1:0]    ph, ph_n;
  logic [4:0]    bit_cnt, bit_cnt_n;
  logic [23:0]   shift, shift_n;
  logic          busy_n, done_n, ack_err_n, scl_n, sda_oe_n;
  logic          sda_s1, sda_s2;
  logic          tick;

  assign tick = (qcnt == QW'(QDIV - 1));

  always_comb begin
    state_n   = state;
    ph_n      = ph;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    busy_n    = busy;
    done_n    = 1'b0;
    ack_err_n = ack_err;
    case (state)
      S_IDLE: begin
        // the done cycle is still IDLE, so a start there must not be taken
        if (start && !done) begin
          state_n   = S_START;
          ph_n      = 2'd0;
          shift_n   = data_in;
          bit_cnt_n = 5'd0;
          busy_n    = 1'b1;
          ack_err_n = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          ph_n = ph + 2'd1;
          if (ph == 2'd1) begin
            state_n = S_BIT;
            ph_n    = 2'd0;
          end
        end
      end
      S_BIT: begin
        if (tick) begin
          ph_n = ph + 2'd1;
          if (ph == 2'd3) begin
            shift_n   = {shift[22:0], 1'b0};
            bit_cnt_n = bit_cnt + 5'd1;
            state_n   = (bit_cnt[2:0] == 3'd7) ? S_ACK : S_BIT;
          end
        end
      end
      S_ACK: begin
        if (tick) begin
          ph_n = ph + 2'd1;
          if (ph == 2'd2 && sda_s2)
            ack_err_n = 1'b1;
          if (ph == 2'd3)
            state_n = (ack_err || bit_cnt == 5'd24) ? S_STOP : S_BIT;
        end
      end
      S_STOP: begin
        if (tick) begin
          ph_n = ph + 2'd1;
          if (ph == 2'd3) begin
            state_n = S_FREE;
            ph_n    = 2'd0;
          end
        end
      end
      S_FREE: begin
        if (tick) begin
          ph_n = ph + 2'd1;
          if (ph == 2'd1) begin
            state_n = S_IDLE;
            ph_n    = 2'd0;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // pad levels are decoded from the next state so the registered pins line up with it
    scl_n    = 1'b1;
    sda_oe_n = 1'b0;
    case (state_n)
      S_START: sda_oe_n = 1'b1;
      S_BIT: begin
        scl_n    = ph_n[1];
        sda_oe_n = ~shift_n[23];
      end
      S_ACK:  scl_n = ph_n[1];
      S_STOP: begin
        scl_n    = ph_n[1];
        sda_oe_n = (ph_n != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      qcnt    <= '0;
      ph      <= 2'd0;
      bit_cnt <= 5'd0;
      shift   <= 24'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      scl     <= 1'b1;
      sda_oe  <= 1'b0;
      sda_s1  <= 1'b1;
      sda_s2  <= 1'b1;
    end else begin
      state   <= state_n;
      qcnt    <= (state == S_IDLE || tick) ? '0 : qcnt + QW'(1);
      ph      <= ph_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      busy    <= busy_n;
      done    <= done_n;
      ack_err <= ack_err_n;
      scl     <= scl_n;
      sda_oe  <= sda_oe_n;
      sda_s1  <= sda_in;
      sda_s2  <= sda_s1;
    end
  end

endmodule

// File: tb/tb_i2c_wr24_master.sv
// Directed bench for i2c_wr24_master with a passive I2C slave model that ACKs/NACKs per byte.
`timescale 1ns/1ps
module tb_i2c_wr24_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] data_in = 24'd0;
  logic        busy, done, ack_err, scl, sda_oe;
  logic        sda_line;
  logic        ack_drive = 1'b0;
  logic [2:0]  ack_en = 3'b111;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // slave model state
  int          start_cnt = 0, stop_cnt = 0, done_cnt = 0, rise_cnt = 0;
  int          last_rise = 0, min_per = 0, max_per = 0;
  logic [23:0] rx = 24'd0;
  logic        prev_scl = 1'b1, prev_sda = 1'b1;

  assign sda_line = ~(sda_oe | ack_drive);

  i2c_wr24_master dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .scl     (scl),
    .sda_oe  (sda_oe),
    .sda_in  (sda_line)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic cur_sda;
    int   per;
    cur_sda = sda_line;
    if (done === 1'b1) done_cnt++;
    if (prev_scl && scl) begin
      if (prev_sda && !cur_sda) begin
        start_cnt++;
        rise_cnt = 0;
        rx       = 24'd0;
        min_per  = 32'h7fffffff;
        max_per  = 0;
      end else if (!prev_sda && cur_sda) begin
        stop_cnt++;
      end
    end
    if (!prev_scl && scl) begin
      if (rise_cnt > 0) begin
        per = cyc - last_rise;
        if (per < min_per) min_per = per;
        if (per > max_per) max_per = per;
      end
      last_rise = cyc;
      if (rise_cnt < 27 && (rise_cnt % 9) != 8) rx = {rx[22:0], cur_sda};
      rise_cnt++;
    end
    if (prev_scl && !scl)
      ack_drive = ((rise_cnt % 9) == 8 && rise_cnt < 27) ? ack_en[rise_cnt / 9] : 1'b0;
    prev_scl = scl;
    prev_sda = cur_sda;
  end

  task automatic run_xfer(input string tag, input logic [23:0] w, input logic [2:0] acks,
                          input int exp_lat, input logic exp_err, input int inj_cyc,
                          input int rst_cyc, input bit start_at_done);
    int n, s0, p0, d0;
    s0 = start_cnt; p0 = stop_cnt; d0 = done_cnt;
    ack_en = acks;
    @(negedge clk);
    start   = 1'b1;
    data_in = w;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    data_in = ~w;
    check({tag, " busy_after_start"}, busy, 1'b1);
    check({tag, " ack_err_cleared"}, ack_err, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 20000) begin
      if (n == inj_cyc - 1) begin
        start   = 1'b1;
        data_in = 24'hFFFFFF;
      end else begin
        start = 1'b0;
      end
      if (n == exp_lat - 1) check({tag, " busy_before_done"}, busy, 1'b1);
      if (n == rst_cyc) break;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (rst_cyc >= 0) begin
      rst = 1'b1;
      #1;
      check({tag, " rst_scl"}, scl, 1'b1);
      check({tag, " rst_sda_oe"}, sda_oe, 1'b0);
      check({tag, " rst_busy"}, busy, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check({tag, " rst_no_done"}, done_cnt - d0, 0);
      check({tag, " rst_no_stop"}, stop_cnt - p0, 0);
      return;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " busy_at_done"}, busy, 1'b0);
    check({tag, " ack_err"}, ack_err, exp_err);
    if (start_at_done) begin
      start   = 1'b1;
      data_in = 24'h123456;
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, " done_one_cycle"}, done, 1'b0);
    check({tag, " stays_idle"}, busy, 1'b0);
    repeat (50) @(negedge clk);
    check({tag, " done_pulses"}, done_cnt - d0, 1);
    check({tag, " start_cnt"}, start_cnt - s0, 1);
    check({tag, " stop_cnt"}, stop_cnt - p0, 1);
    check({tag, " scl_rises"}, rise_cnt, exp_err ? 10 : 28);
    check({tag, " scl_min_period"}, min_per, 500);
    check({tag, " scl_max_period"}, max_per, 500);
    if (!exp_err) check({tag, " rx_word"}, rx, w);
    check({tag, " idle_scl"}, scl, 1'b1);
    check({tag, " idle_sda_oe"}, sda_oe, 1'b0);
  endtask

  initial begin
    // reset held 3 cycles, then 100 idle cycles
    repeat (3) begin
      @(negedge clk);
      check("reset_scl", scl, 1'b1);
      check("reset_sda_oe", sda_oe, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_ack_err", ack_err, 1'b0);
    end
    rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      check("idle_scl", scl, 1'b1);
      check("idle_sda_oe", sda_oe, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
    end

    // full ACKed write, plus a start pulse landing in the done cycle
    run_xfer("aa3cc3", 24'hAA3CC3, 3'b111, 14500, 1'b0, -1, -1, 1'b1);
    // NACK on the address byte
    run_xfer("nack_b1", 24'h341E00, 3'b110, 5500, 1'b1, -1, -1, 1'b0);
    // WM8731 power-down word; start re-pulsed at cycle 3000 is ignored
    run_xfer("wm_pd_repulse", 24'h340C00, 3'b111, 14500, 1'b0, 3000, -1, 1'b0);
    // reset mid-byte, then a normal transfer afterwards
    run_xfer("rst_mid", 24'hAA3CC3, 3'b111, 14500, 1'b0, -1, 7000, 1'b0);
    run_xfer("after_rst", 24'h340C00, 3'b111, 14500, 1'b0, -1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_wr24_master.md
Name: i2c_wr24_master

Overview:
- Single-transaction I2C write master that serialises one 24-bit WM8731 control word onto the codec's 2-wire bus.
- Word layout: device address + R/W byte, then register/data high byte, then data low byte.
- Sits between the configuration sequencer, which presents words and pulses `start`, and the SCL/SDA pads.
- This is the stage the bench's I2C functional model listens to: START detect, SCL period check, 24-bit compare, STOP detect.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- SCL_FREQ, 100000, SCL frequency in Hz.
- QDIV, CLK_FREQ/(4*SCL_FREQ) = 125, clock cycles per SCL quarter-period. Derived localparam; must be ≥2.

Ports:
- clk, input, 1, system clock (50 MHz).
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle request; sampled only in IDLE.
- data_in, input, 24, word to send, MSB first; latched on accepted start.
- busy, output, 1, high from the accepted start through the cycle before done.
- done, output, 1, one-cycle pulse at transaction end.
- ack_err, output, 1, set on any NACK; cleared on the next accepted start.
- scl, output, 1, SCL, push-pull (WM8731 never stretches the clock).
- sda_oe, output, 1, 1 = pull SDA low; 0 = release (pad pull-up).
- sda_in, input, 1, SDA pad level; passed through a 2-flop synchroniser.

Behaviour:
- Reset (async, immediate):
  - scl=1, sda_oe=0, busy=0, done=0, ack_err=0.
  - State IDLE; quarter counter, bit counter and shift register all 0.
- Timebase: quarter counter runs 0..QDIV-1 while not IDLE. A "tick" is the wrap. Every phase below lasts a whole number of ticks.
- States:
  - IDLE: scl=1, sda_oe=0. On start=1, in the same edge: latch data_in, busy<=1, ack_err<=0, go to START.
  - START (2 ticks): scl=1, sda_oe=1. SDA falls while SCL is high. Go to BIT with bit counter 0.
  - BIT (4 ticks per bit):
    - q0–q1: scl=0, sda_oe = ~shift[23].
    - q2–q3: scl=1.
    - After q3: shift left by 1, bit_cnt++.
    - After bits 7, 15 and 23, go to ACK.
    - SDA changes only while SCL is low.
  - ACK (4 ticks): q0–q1 scl=0, sda_oe=0; q2–q3 scl=1.
    - Sample synchronised sda_in at the end of q2.
    - Sample 1 (NACK): ack_err<=1, go to STOP, remaining bytes abandoned.
    - Sample 0 after the third byte: go to STOP.
    - Sample 0 otherwise: return to BIT.
  - STOP (4 ticks): q0–q1 scl=0, sda_oe=1; q2 scl=1, sda_oe=1; q3 scl=1, sda_oe=0. SDA rises while SCL is high.
  - FREE (2 ticks): bus idle, guarantees bus-free time. At its end: done=1 for one cycle, busy=0, go to IDLE.
- Latency, no NACK: (2 + 27×4 + 4 + 2) × QDIV = 116 × 125 = 14500 cycles from the accepted start to the done cycle.
- Boundary conditions:
  - start while busy: ignored, no queueing. data_in changes after acceptance have no effect.
  - start in the same cycle as done: ignored. A new start is accepted from the following IDLE cycle.
  - NACK on byte 1: ack_err=1; done after (2 + 9×4 + 4 + 2) × 125 = 5500 cycles.
  - Reset mid-transfer: bus released at once (scl=1, sda_oe=0); no STOP is generated.
  - sda_in is ignored outside the ACK q2 sample point.
- All outputs are registered; no combinational path from input to output.

Test Plan:
1. Reset held 3 cycles, then released and idle 100 cycles -> scl=1, sda_oe=0, busy=0, done=0 throughout.
2. start with data_in=24'hAA3CC3; bench ACKs all 3 bytes -> START seen, SCL period 500 clocks (10 µs), received word 1010_1010_0011_1100_1100_0011, STOP seen, done at cycle 14500, ack_err=0.
3. WM8731 word 24'h340C00 (addr 0x34 write, reg 6 power-down = 0); bench ACKs -> bits match MSB first; SDA never toggles while SCL high except at START/STOP.
4. Bench NACKs the first byte of 24'h34_1E_00 -> ack_err=1, STOP follows that ACK slot, done at cycle 5500. Next start clears ack_err.
5. start re-pulsed with 24'hFFFFFF at cycle 3000 of a transfer -> ignored; original word completes unchanged; only one done pulse.
6. rst asserted at cycle 7000 mid-byte -> scl=1 and sda_oe=0 asynchronously, busy=0. After release, a new start completes normally.
